// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants for the iterative double-dabble converter: FSM encoding and
// BCD digit adjust parameters.
package bin2bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0] ADJ_THRESH = 4'd5;
    localparam logic [3:0] ADJ_ADD = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    always_comb begin
        dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary to packed-BCD converter, one input bit per clock. Results are
// registered and held between o_done pulses; top-digit carry-out flags overflow.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [BIN_W-1:0]          i_bin,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [DIGIT_W*DIGITS-1:0] o_bcd,
    output logic                      o_ovf
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned ACC_W = DIGIT_W * DIGITS;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_adj;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   bcd_q, bcd_d;
    logic               ovf_out_q, ovf_out_d;
    logic               done_q, done_d;
    logic               accept;
    logic               last_iter;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_q[k*DIGIT_W +: DIGIT_W]),
            .dout (acc_adj[k*DIGIT_W +: DIGIT_W])
        );
    end

    assign accept    = i_start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_iter = (cnt_q == CNT_W'(BIN_W - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            ovf_out_q <= ovf_out_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        ovf_out_d = ovf_out_q;
        done_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                {acc_d, shreg_d} = {acc_adj, shreg_q} << 1;
                ovf_d = ovf_q | acc_adj[ACC_W-1];
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = ST_DONE;
            end
            ST_DONE: begin
                bcd_d     = acc_q;
                ovf_out_d = ovf_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Acceptance overrides the IDLE/DONE defaults above; SHIFT never accepts.
        if (accept) begin
            shreg_d = i_bin;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_SHIFT;
        end
    end

    always_comb begin
        o_busy = (state_q == ST_SHIFT);
        o_done = done_q;
        o_bcd  = bcd_q;
        o_ovf  = ovf_out_q;
    end

endmodule
